// File: rtl/permutation_round_core.sv
// Iterative Ascon-p[rnd] permutation engine: constant addition, bitsliced
// S-box layer and linear diffusion, UNROLL (1 or 2) rounds per clock.

package ascon_pkg;
  localparam int WORD_WIDTH = 64;
  localparam logic [3:0] MAX_ROUNDS = 4'd12;

  typedef logic [WORD_WIDTH-1:0] word_t;

  // S0 is the most significant word, so it is also the MSB of every S-box slice.
  typedef struct packed {
    word_t s0;
    word_t s1;
    word_t s2;
    word_t s3;
    word_t s4;
  } ascon_state_t;

  function automatic word_t ror(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_WIDTH - n));
  endfunction

  function automatic ascon_state_t linear_layer(input ascon_state_t s);
    ascon_state_t o;
    o.s0 = s.s0 ^ ror(s.s0, 19) ^ ror(s.s0, 28);
    o.s1 = s.s1 ^ ror(s.s1, 61) ^ ror(s.s1, 39);
    o.s2 = s.s2 ^ ror(s.s2, 1)  ^ ror(s.s2, 6);
    o.s3 = s.s3 ^ ror(s.s3, 10) ^ ror(s.s3, 17);
    o.s4 = s.s4 ^ ror(s.s4, 7)  ^ ror(s.s4, 41);
    return o;
  endfunction

  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {4'd15 - r, r};
  endfunction
endpackage

module substitution_layer
  import ascon_pkg::*;
(
  input  ascon_state_t din,
  output ascon_state_t dout
);
  word_t a0, a2, a4;
  word_t b0, b1, b2, b3, b4;

  // Bitsliced 5-bit S-box: pre-mix, chi-like nonlinear step, post-mix.
  assign a0 = din.s0 ^ din.s4;
  assign a2 = din.s2 ^ din.s1;
  assign a4 = din.s4 ^ din.s3;

  assign b0 = a0     ^ (~din.s1 & a2);
  assign b1 = din.s1 ^ (~a2     & din.s3);
  assign b2 = a2     ^ (~din.s3 & a4);
  assign b3 = din.s3 ^ (~a4     & a0);
  assign b4 = a4     ^ (~a0     & din.s1);

  assign dout.s0 = b0 ^ b4;
  assign dout.s1 = b1 ^ b0;
  assign dout.s2 = ~b2;
  assign dout.s3 = b3 ^ b2;
  assign dout.s4 = b4;
endmodule

module permutation_round_core
  import ascon_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  output logic         ready_o,
  input  logic [3:0]   rounds_i,
  input  ascon_state_t state_i,
  output ascon_state_t state_o,
  output logic         valid_o,
  input  logic         ready_i
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t         fsm_q, fsm_d;
  ascon_state_t state_q;
  logic [3:0]   rnd_q, i_q, i_next, rnd_in, remaining;
  logic         accept, use_two;
  ascon_state_t stage_in  [UNROLL];
  ascon_state_t stage_out [UNROLL];
  ascon_state_t round_out;

  assign accept    = start_i && ready_o;
  assign rnd_in    = (rounds_i > MAX_ROUNDS) ? MAX_ROUNDS : rounds_i;
  assign remaining = rnd_q - i_q;

  // With one round left, the second chained datapath is bypassed.
  assign use_two   = (UNROLL == 2) && (remaining != 4'd1);
  assign i_next    = i_q + (use_two ? 4'd2 : 4'd1);
  assign round_out = use_two ? stage_out[UNROLL-1] : stage_out[0];

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    ascon_state_t added, sboxed;
    logic [3:0]   r;

    if (g == 0) begin : g_first
      assign stage_in[g] = state_q;
    end else begin : g_chain
      assign stage_in[g] = stage_out[g-1];
    end

    // r <= 11 for every applied round, so 4-bit arithmetic never wraps.
    assign r = MAX_ROUNDS - rnd_q + i_q + 4'(g);

    always_comb begin
      added          = stage_in[g];
      added.s2[7:0]  = stage_in[g].s2[7:0] ^ round_const(r);
    end

    substitution_layer u_sbox (
      .din  (added),
      .dout (sboxed)
    );

    assign stage_out[g] = linear_layer(sboxed);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the wide state register is reset too, so state_o reads zero after reset.
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      i_q     <= '0;
      valid_o <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      valid_o <= (fsm_d == DONE);
      case (fsm_q)
        IDLE: if (accept) begin
          state_q <= state_i;
          rnd_q   <= rnd_in;
          i_q     <= '0;
        end
        RUN: begin
          state_q <= round_out;
          i_q     <= i_next;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (accept) fsm_d = (rnd_in != 4'd0) ? RUN : DONE;
      RUN:     if (i_next == rnd_q) fsm_d = DONE;
      DONE:    if (ready_i) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // ready_o is held low during the reset cycle even if the FSM is already idle.
  always_comb begin
    ready_o = (fsm_q == IDLE) && !rst_i;
    state_o = state_q;
  end
endmodule

// File: tb/tb_permutation_round_core.sv
// Directed bench for permutation_round_core: one DUT per UNROLL value, a
// table-driven Ascon-p reference model and a queue-based scoreboard.

module tb_permutation_round_core;
  import ascon_pkg::*;

  typedef struct {
    ascon_state_t st;
    int           lat;
  } exp_t;

  localparam logic [0:31][4:0] SBOX_T = {
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         start  [2];
  logic [3:0]   rounds [2];
  ascon_state_t sin    [2];
  ascon_state_t sout   [2];
  logic         rdy_o  [2];
  logic         vld    [2];
  logic         rdy_i  [2];

  exp_t sb0[$];
  exp_t sb1[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  permutation_round_core #(.UNROLL(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .ready_o(rdy_o[0]),
    .rounds_i(rounds[0]), .state_i(sin[0]), .state_o(sout[0]),
    .valid_o(vld[0]), .ready_i(rdy_i[0])
  );

  permutation_round_core #(.UNROLL(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .ready_o(rdy_o[1]),
    .rounds_i(rounds[1]), .state_i(sin[1]), .state_o(sout[1]),
    .valid_o(vld[1]), .ready_i(rdy_i[1])
  );

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x};
    return d[n +: 64];
  endfunction

  function automatic ascon_state_t ref_perm(input ascon_state_t s, input int rnd);
    logic [63:0] x [5];
    ascon_state_t o;
    x[0] = s.s0; x[1] = s.s1; x[2] = s.s2; x[3] = s.s3; x[4] = s.s4;
    for (int i = 0; i < rnd; i++) begin
      int r;
      r = 12 - rnd + i;
      x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        logic [4:0] v, w;
        v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        w = SBOX_T[v];
        {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]} = w;
      end
      x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
      x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
      x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
      x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
      x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
    end
    o.s0 = x[0]; o.s1 = x[1]; o.s2 = x[2]; o.s3 = x[3]; o.s4 = x[4];
    return o;
  endfunction

  function automatic ascon_state_t rand_state();
    ascon_state_t s;
    for (int k = 0; k < 10; k++) s[k*32 +: 32] = $urandom;
    return s;
  endfunction

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic start_job(input int sel, input logic [3:0] r, input ascon_state_t st);
    exp_t e;
    int   rnd, u;
    u     = sel + 1;
    rnd   = (r > 4'd12) ? 12 : int'(r);
    e.st  = ref_perm(st, rnd);
    e.lat = (rnd + u - 1) / u + 1;
    if (sel == 0) sb0.push_back(e); else sb1.push_back(e);
    check($sformatf("ready_at_accept_u%0d", u), 320'(rdy_o[sel]), 320'(1));
    start[sel]  = 1'b1;
    rounds[sel] = r;
    sin[sel]    = st;
    @(negedge clk);
    start[sel]  = 1'b0;
    rounds[sel] = 4'($urandom);
    sin[sel]    = rand_state();
  endtask

  // Waits for valid_o, checks latency and result, optionally stalls, then hands off.
  task automatic wait_result(input int sel, input int hold, input bit pulse,
                             output ascon_state_t got);
    exp_t e;
    int   lat;
    bit   stable;
    lat = 1;
    while (!vld[sel] && lat < 100) begin
      if (pulse) begin
        start[sel] = lat[0];
        rdy_i[sel] = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    start[sel] = 1'b0;
    if (hold > 0) rdy_i[sel] = 1'b0;
    got = sout[sel];
    if (sel == 0) e = sb0.pop_front(); else e = sb1.pop_front();
    check($sformatf("latency_u%0d", sel + 1), 320'(lat), 320'(e.lat));
    check($sformatf("result_u%0d", sel + 1), got, e.st);
    stable = 1'b1;
    repeat (hold) begin
      if (pulse) start[sel] = ~start[sel];
      @(negedge clk);
      stable &= (vld[sel] === 1'b1) && (sout[sel] === got);
    end
    if (hold > 0) check($sformatf("hold_stable_u%0d", sel + 1), 320'(stable), 320'(1));
    start[sel] = 1'b0;
    rdy_i[sel] = 1'b1;
    @(negedge clk);
    check($sformatf("valid_drop_u%0d", sel + 1), 320'(vld[sel]), 320'(0));
    check($sformatf("ready_back_u%0d", sel + 1), 320'(rdy_o[sel]), 320'(1));
    rdy_i[sel] = 1'b0;
  endtask

  initial begin
    ascon_state_t st, g0, g1;
    int           rl [3];
    bit           quiet;
    rl = '{6, 8, 12};
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0; rounds[s] = '0; sin[s] = '0; rdy_i[s] = 1'b0;
    end

    // Reset values.
    @(negedge clk);
    check("ready_in_reset_u1", 320'(rdy_o[0]), 320'(0));
    check("ready_in_reset_u2", 320'(rdy_o[1]), 320'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_ready_u%0d", s + 1), 320'(rdy_o[s]), 320'(1));
      check($sformatf("rst_valid_u%0d", s + 1), 320'(vld[s]), 320'(0));
      check($sformatf("rst_state_u%0d", s + 1), sout[s], 320'(0));
    end

    // Zero state, one round: known S2 and S4 words.
    start_job(0, 4'd1, '0);
    wait_result(0, 0, 1'b0, g0);
    check("zero_r1_s2", 320'(g0.s2), 320'(64'h53FF_FFFF_FFFF_FF90));
    check("zero_r1_s4", 320'(g0.s4), 320'(0));

    // Random states at 6/8/12 rounds on both unroll factors.
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 3; k++) begin
        start_job(s, 4'(rl[k]), rand_state());
        wait_result(s, 0, 1'b0, g0);
      end
    end

    // Odd round count with UNROLL=2 matches UNROLL=1.
    st = rand_state();
    start_job(0, 4'd7, st);
    wait_result(0, 0, 1'b0, g0);
    start_job(1, 4'd7, st);
    wait_result(1, 0, 1'b0, g1);
    check("u2_vs_u1_r7", g1, g0);

    // Zero rounds is a pass-through.
    for (int s = 0; s < 2; s++) begin
      st = rand_state();
      start_job(s, 4'd0, st);
      wait_result(s, 0, 1'b0, g0);
      check($sformatf("passthru_u%0d", s + 1), g0, st);
    end

    // 15 rounds clamps to 12.
    st = rand_state();
    start_job(1, 4'd15, st);
    wait_result(1, 0, 1'b0, g1);
    start_job(1, 4'd12, st);
    wait_result(1, 0, 1'b0, g0);
    check("clamp_15_eq_12", g1, g0);

    // Backpressure with start/ready_i noise, then a back-to-back request.
    for (int s = 0; s < 2; s++) begin
      start_job(s, 4'd12, rand_state());
      wait_result(s, 20, 1'b1, g0);
      start_job(s, 4'd8, rand_state());
      wait_result(s, 0, 1'b0, g0);
    end

    // Reset in the fifth RUN cycle of a 12-round job abandons it.
    start_job(0, 4'd12, rand_state());
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_ready", 320'(rdy_o[0]), 320'(0));
    rst = 1'b0;
    sb0.delete();
    @(negedge clk);
    check("midrun_after_ready", 320'(rdy_o[0]), 320'(1));
    check("midrun_after_valid", 320'(vld[0]), 320'(0));
    check("midrun_after_state", sout[0], 320'(0));
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      quiet &= (vld[0] === 1'b0);
    end
    check("aborted_no_valid", 320'(quiet), 320'(1));
    start_job(0, 4'd12, rand_state());
    wait_result(0, 0, 1'b0, g0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
